// File: rtl/of_ex_skid_buffer.sv
// OF->EX pipeline boundary: two-entry skid buffer with registered ready,
// branch-flush kill and a saturating stall-cycle counter.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               drop every buffered bundle
//   in_valid/in_ready   upstream handshake (in_ready is a register decode)
//   in_pc..in_ctrl      operand-fetch bundle
//   out_valid/out_ready execute handshake (out_valid is a register decode)
//   out_pc..out_ctrl    main entry fields
//   clr_stats           synchronous clear of stall_count
//   stall_count         cycles with out_valid & !out_ready, saturating
module of_ex_skid_buffer #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 22,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_inst,
   input  logic [DATA_W-1:0] in_op1,
   input  logic [DATA_W-1:0] in_op2,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_inst,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              clr_stats,
   output logic [CNT_W-1:0]  stall_count
);

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] inst;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [CTRL_W-1:0] ctrl;
   } bun_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   bun_t             main_q, skid_q, in_b;
   logic             accept, consume;
   logic             ld_main_in, ld_main_skid, ld_skid;
   logic [CNT_W-1:0] cnt_q;

   assign in_b = {in_pc, in_inst, in_op1, in_op2, in_ctrl};

   // Handshake outputs decode only the state register.
   assign out_valid = (state_q != EMPTY);
   assign in_ready  = (state_q != FULL);

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush) begin
         // Kill wins; a same-cycle input is dropped.
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  ld_main_in = 1'b1;
                  state_d    = ONE;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  ld_main_in = 1'b1;
               end else if (accept) begin
                  ld_skid = 1'b1;
                  state_d = FULL;
               end else if (consume) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (consume) begin
                  ld_main_skid = 1'b1;
                  state_d      = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (ld_main_in) begin
            main_q <= in_b;
         end else if (ld_main_skid) begin
            main_q <= skid_q;
         end
         if (ld_skid) begin
            skid_q <= in_b;
         end
      end
   end

   assign out_pc   = main_q.pc;
   assign out_inst = main_q.inst;
   assign out_op1  = main_q.op1;
   assign out_op2  = main_q.op2;
   assign out_ctrl = main_q.ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_stats) begin
         cnt_q <= '0;
      end else if (out_valid && !out_ready
                   && cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign stall_count = cnt_q;

endmodule

// File: tb/tb_of_ex_skid_buffer.sv
// Bench for of_ex_skid_buffer: queue model checked every cycle plus
// directed literal expectations; a CNT_W=4 copy covers saturation.
module tb_of_ex_skid_buffer;

   localparam int DW = 32;
   localparam int CW = 22;

   typedef struct packed {
      logic [DW-1:0] pc;
      logic [DW-1:0] inst;
      logic [DW-1:0] op1;
      logic [DW-1:0] op2;
      logic [CW-1:0] ctrl;
   } bun_t;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, out_ready, clr_stats;
   logic [DW-1:0] in_pc, in_inst, in_op1, in_op2;
   logic [CW-1:0] in_ctrl;

   logic          in_ready, out_valid;
   logic [DW-1:0] out_pc, out_inst, out_op1, out_op2;
   logic [CW-1:0] out_ctrl;
   logic [15:0]   stall_count;

   logic          s_in_ready, s_out_valid;
   logic [DW-1:0] s_pc, s_inst, s_op1, s_op2;
   logic [CW-1:0] s_ctrl;
   logic [3:0]    s_stall;

   int total = 0;
   int bad   = 0;

   bun_t q[$];
   bun_t m_main;
   int   m_cnt16, m_cnt4;

   always #5 clk = ~clk;

   of_ex_skid_buffer u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst),
      .in_op1(in_op1), .in_op2(in_op2),
      .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst),
      .out_op1(out_op1), .out_op2(out_op2),
      .out_ctrl(out_ctrl),
      .clr_stats(clr_stats), .stall_count(stall_count)
   );

   of_ex_skid_buffer #(.CNT_W(4)) u_small (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_pc(in_pc), .in_inst(in_inst),
      .in_op1(in_op1), .in_op2(in_op2),
      .in_ctrl(in_ctrl),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_pc(s_pc), .out_inst(s_inst),
      .out_op1(s_op1), .out_op2(s_op2),
      .out_ctrl(s_ctrl),
      .clr_stats(clr_stats), .stall_count(s_stall)
   );

   function automatic bun_t mk(input logic [DW-1:0] pc);
      bun_t b;
      b.pc   = pc;
      b.inst = pc ^ 32'hA5A5_5A5A;
      b.op1  = pc + 32'd100;
      b.op2  = ~pc;
      b.ctrl = pc[CW-1:0] ^ 22'h15_5AA5;
      return b;
   endfunction

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic present(input logic v,
                          input logic [DW-1:0] pc);
      bun_t b;
      b = mk(pc);
      in_valid = v;
      in_pc    = b.pc;
      in_inst  = b.inst;
      in_op1   = b.op1;
      in_op2   = b.op2;
      in_ctrl  = b.ctrl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: a FIFO of at most two bundles.
   initial begin
      bit acc, con;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            q.delete();
            m_main  = '0;
            m_cnt16 = 0;
            m_cnt4  = 0;
         end else begin
            acc = in_valid && (q.size() < 2);
            con = (q.size() > 0) && out_ready;
            if (clr_stats) begin
               m_cnt16 = 0;
               m_cnt4  = 0;
            end else if (q.size() > 0 && !out_ready) begin
               if (m_cnt16 < 65535) m_cnt16++;
               if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush) begin
               q.delete();
            end else begin
               if (con) void'(q.pop_front());
               if (acc) q.push_back(mk(in_pc));
            end
            if (q.size() > 0) m_main = q[0];
         end
      end
   end

   // Per-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
         chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
         chk("stall16", 64'(stall_count), 64'(m_cnt16));
         chk("stall4", 64'(s_stall), 64'(m_cnt4));
         chk("s_valid", 64'(s_out_valid), 64'(q.size() > 0));
         chk("s_ready", 64'(s_in_ready), 64'(q.size() < 2));
         if (out_valid) begin
            chk("out_pc", 64'(out_pc), 64'(m_main.pc));
            chk("out_inst", 64'(out_inst), 64'(m_main.inst));
            chk("out_op1", 64'(out_op1), 64'(m_main.op1));
            chk("out_op2", 64'(out_op2), 64'(m_main.op2));
            chk("out_ctrl", 64'(out_ctrl), 64'(m_main.ctrl));
            chk("s_pc", 64'(s_pc), 64'(m_main.pc));
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      clr_stats = 1'b0;
      present(1'b0, 32'h0);
      step();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_stall", 64'(stall_count), 64'd0);
      chk("rst_op1", 64'(out_op1), 64'd0);
      step();
      rst_n = 1'b1;

      // Back-to-back stream.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         present(1'b1, 32'(i * 4));
         step();
         chk("str_v", 64'(out_valid), 64'd1);
         chk("str_pc", 64'(out_pc), 64'(i * 4));
      end
      present(1'b0, 32'h0);
      step();
      chk("str_end", 64'(out_valid), 64'd0);

      // Backpressure fill to FULL.
      present(1'b1, 32'h10);
      step();
      present(1'b1, 32'h14);
      out_ready = 1'b0;
      step();
      chk("bp_rdy", 64'(in_ready), 64'd0);
      chk("bp_pc0", 64'(out_pc), 64'h10);
      present(1'b1, 32'h18);
      step();
      step();
      chk("bp_hold", 64'(out_pc), 64'h10);
      out_ready = 1'b1;
      step();
      chk("bp_pc1", 64'(out_pc), 64'h14);
      chk("bp_rdy1", 64'(in_ready), 64'd1);
      step();
      chk("bp_pc2", 64'(out_pc), 64'h18);
      present(1'b0, 32'h0);
      step();

      // Accept and consume together in ONE.
      present(1'b1, 32'h30);
      step();
      present(1'b1, 32'h34);
      step();
      chk("swap_pc", 64'(out_pc), 64'h34);
      chk("swap_rdy", 64'(in_ready), 64'd1);
      present(1'b0, 32'h0);
      step();

      // Flush while FULL with a bundle presented.
      out_ready = 1'b0;
      present(1'b1, 32'h40);
      step();
      present(1'b1, 32'h44);
      step();
      present(1'b1, 32'h20);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_ready", 64'(in_ready), 64'd1);
      present(1'b0, 32'h0);
      out_ready = 1'b1;
      repeat (3) step();

      // Stall counter.
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      chk("st_clr0", 64'(stall_count), 64'd0);
      out_ready = 1'b0;
      present(1'b1, 32'h50);
      step();
      present(1'b0, 32'h0);
      repeat (5) step();
      chk("st_five", 64'(stall_count), 64'd5);
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      chk("st_clr1", 64'(stall_count), 64'd0);
      repeat (20) step();
      chk("st_twenty", 64'(stall_count), 64'd20);
      chk("st_sat", 64'(s_stall), 64'd15);

      // Async reset while FULL, between edges.
      present(1'b1, 32'h54);
      step();
      present(1'b0, 32'h0);
      chk("ar_full", 64'(in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_ready", 64'(in_ready), 64'd1);
      chk("ar_op1", 64'(out_op1), 64'd0);
      chk("ar_stall", 64'(stall_count), 64'd0);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      present(1'b1, 32'h60);
      step();
      chk("post_pc", 64'(out_pc), 64'h60);
      present(1'b0, 32'h0);
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/of_ex_skid_buffer.md
# of_ex_skid_buffer

Pipeline boundary between operand fetch and execute in the tinyRISC core. It captures the operand-fetch bundle: PC, instruction, op1, op2 and the control vector. It presents that bundle to execute through a valid/ready handshake, using a two-entry skid buffer so that `in_ready` is fully registered. It also supports a branch-flush kill and a saturating stall-cycle counter for performance debug.

## Interface
- `DATA_W`, 32, width of pc, inst, op1, op2
- `CTRL_W`, 22, width of decoded control vector (isRet, isSt, ... packed)
- `CNT_W`, 16, width of stall counter

- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `flush`  in  1  kill all buffered entries (taken branch / ret from EX)
- `in_valid`  in  1  operand-fetch bundle valid
- `in_ready`  out  1  buffer can accept (registered)
- `in_pc`, `in_inst`, `in_op1`, `in_op2`  in  DATA_W each  bundle fields
- `in_ctrl`  in  CTRL_W  control vector
- `out_valid`  out  1  bundle available to execute (registered)
- `out_ready`  in  1  execute consumes this cycle
- `out_pc`, `out_inst`, `out_op1`, `out_op2`  out  DATA_W each  registered fields
- `out_ctrl`  out  CTRL_W  registered control vector
- `clr_stats`  in  1  synchronous clear of `stall_count`
- `stall_count`  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main entry (valid bit M plus fields) and skid entry (valid bit S plus fields).
- States: EMPTY (M=0,S=0), ONE (M=1,S=0), FULL (M=1,S=1). M=0,S=1 is unreachable.
- `out_valid` = M. Out fields are driven from the main entry. `in_ready` = !S.
- accept = in_valid & in_ready. consume = M & out_ready.
- EMPTY: on accept, main <= in and the state goes to ONE. Otherwise it stays EMPTY.
- ONE, accept & consume: main <= in, stay in ONE.
- ONE, accept & !consume: skid <= in, go to FULL.
- ONE, !accept & consume: go to EMPTY.
- ONE, neither: hold.
- FULL (in_ready=0): on consume, main <= skid and the state goes to ONE. Otherwise hold. Input is never accepted in FULL.
- Ordering is strictly FIFO and no bundle is duplicated or dropped except by flush.
- flush has the highest priority.
  - Next state is EMPTY regardless of accept/consume.
  - A bundle presented with in_valid during the flush cycle is discarded. Upstream treats it as killed.
  - A consume in the flush cycle is a completed transfer. Execute owns the decision whether to use it.
- Field registers need not be cleared on flush; only M and S clear.
- stall_count:
  - Increments by 1 each cycle with M & !out_ready.
  - Holds at 2^CNT_W-1.
  - clr_stats takes priority over the increment: next value is 0.
  - flush does not affect it.
- Reset (rst_n=0, asynchronous):
  - M=S=0, so out_valid=0 and in_ready=1.
  - All out fields are 0 and stall_count=0.
  - Applies mid-transfer; in-flight bundles are lost.

## Timing
- Latency: from accept in EMPTY, out_valid=1 with the new fields in the next cycle.
- Throughput: 1 bundle/cycle sustained while out_ready=1.
- in_ready falls in the cycle after the skid fills (the cycle after accept & !consume in ONE).
- in_ready rises in the cycle after the consume from FULL.
- No combinational path from out_ready or in_valid to in_ready or out_valid.
- out fields change only on a clock edge and stay stable while out_valid=1 & out_ready=0.
- flush asserted in cycle t: out_valid=0 and in_ready=1 in t+1.

## Test plan
- Reset then stream: pulse rst_n low, check out_valid=0, in_ready=1, stall_count=0. Then drive 4 back-to-back bundles (pc=0x0,0x4,0x8,0xC) with out_ready=1. Each appears exactly 1 cycle after accept, in order.
- Backpressure fill:
  - In EMPTY, present pc=0x10. Next cycle present pc=0x14 with out_ready=0, then hold out_ready=0.
  - State reaches FULL and in_ready=0; pc=0x18 held on in_valid is not accepted.
  - Raise out_ready for 3 cycles: out shows 0x10, 0x14, 0x18 in order.
- Simultaneous accept and consume in ONE: the main entry swaps to the new bundle, S stays 0 and in_ready stays 1.
- Flush in FULL with in_valid=1 (pc=0x20): next cycle out_valid=0, in_ready=1. pc=0x20 never appears on the output.
- Stall counter:
  - Hold out_valid=1, out_ready=0 for 5 cycles: stall_count=5.
  - clr_stats for 1 cycle: stall_count=0.
  - With CNT_W=4, 20 stall cycles give stall_count=15 (saturated).
- Async reset mid-FULL: assert rst_n=0 between edges. out_valid drops immediately, in_ready=1, out_op1=0, and no edge is needed.
